// File: rtl/game_round_controller.sv
// Purpose: sequences one reaction-game session (arm, show target, judge, feedback) and drives screen/score/mistake outputs.
// Latency: outputs are registered; a frame tick is judged on the cycle after it, 3 clocks after iVS falls.
// Backpressure: none; iStart is honoured only in IDLE/DONE, and sensors are sampled only on frame ticks.
module game_round_controller #(
    parameter int          FRAMES_PER_TARGET = 60,
    parameter int          FEEDBACK_FRAMES   = 20,
    parameter int          HIT_MAX           = 40,
    parameter int          NUM_TARGETS       = 16,
    parameter int          MAX_MISTAKES      = 3,
    parameter logic [7:0]  LFSR_SEED         = 8'hA5
) (
    input  logic        iVGA_CLK,
    input  logic        iRST_n,
    input  logic        iVS,
    input  logic        iStart,
    input  logic [20:0] iSensor,
    output logic [31:0] oScreen,
    output logic [1:0]  oTarget,
    output logic        oTargetValid,
    output logic [1:0]  oFeedback,
    output logic [7:0]  oScore,
    output logic [31:0] oMistake,
    output logic        oRoundDone
);

    localparam logic [7:0] FPT_LAST   = 8'(FRAMES_PER_TARGET - 1);
    localparam logic [7:0] FB_LAST    = 8'(FEEDBACK_FRAMES - 1);
    localparam logic [7:0] TGT_TOTAL  = 8'(NUM_TARGETS);
    localparam logic [7:0] MIST_LIMIT = 8'(MAX_MISTAKES);
    localparam logic [6:0] HIT_LIM    = 7'(HIT_MAX);

    localparam logic [1:0] SCR_SPLASH  = 2'd0;
    localparam logic [1:0] SCR_PLAY    = 2'd1;
    localparam logic [1:0] SCR_RESULTS = 2'd2;
    localparam logic [1:0] FB_NONE     = 2'b00;
    localparam logic [1:0] FB_HIT      = 2'b01;
    localparam logic [1:0] FB_MISS     = 2'b10;
    localparam logic [1:0] TGT_NONE    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_SHOW,
        ST_FEEDBACK,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  screen_q, screen_d;
    logic [1:0]  target_q, target_d;
    logic        tvalid_q, tvalid_d;
    logic [1:0]  fb_q, fb_d;
    logic [7:0]  score_q, score_d;
    logic [7:0]  mist_q, mist_d;
    logic        done_q, done_d;
    logic [7:0]  frame_q, frame_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic [7:0]  lfsr_q, lfsr_d;

    logic        vs_s1_q, vs_s2_q, vs_prev_q;
    logic        tick;
    logic [2:0]  pressed;
    logic [2:0]  target_mask;
    logic        hit;
    logic        wrong_pad;
    logic        target_end;
    logic [7:0]  lfsr_next;
    logic [1:0]  lfsr_mod3;

    // iVS is asynchronous: two flops to resynchronise, a third to find the falling edge.
    // Reset high so a low-idle sync line cannot fake a tick right after reset.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            vs_s1_q   <= 1'b1;
            vs_s2_q   <= 1'b1;
            vs_prev_q <= 1'b1;
        end else begin
            vs_s1_q   <= iVS;
            vs_s2_q   <= vs_s1_q;
            vs_prev_q <= vs_s2_q;
        end
    end

    assign tick = vs_prev_q & ~vs_s2_q;

    assign pressed[0] = (iSensor[6:0]   != 7'd0) && (iSensor[6:0]   < HIT_LIM);
    assign pressed[1] = (iSensor[13:7]  != 7'd0) && (iSensor[13:7]  < HIT_LIM);
    assign pressed[2] = (iSensor[20:14] != 7'd0) && (iSensor[20:14] < HIT_LIM);

    // A target of 3 (none) shifts the bit out, so the mask is empty.
    assign target_mask = 3'b001 << target_q;
    assign hit         = |(pressed & target_mask);
    assign wrong_pad   = |(pressed & ~target_mask);

    // Fibonacci LFSR, taps 8,6,5,4, shifting left with feedback into bit 0.
    assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    assign lfsr_mod3 = 2'(lfsr_q % 8'd3);

    // State register and all registered outputs.
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q  <= ST_IDLE;
            screen_q <= SCR_SPLASH;
            target_q <= TGT_NONE;
            tvalid_q <= 1'b0;
            fb_q     <= FB_NONE;
            score_q  <= 8'd0;
            mist_q   <= 8'd0;
            done_q   <= 1'b0;
            frame_q  <= 8'd0;
            tcnt_q   <= 8'd0;
            lfsr_q   <= LFSR_SEED;
        end else begin
            state_q  <= state_d;
            screen_q <= screen_d;
            target_q <= target_d;
            tvalid_q <= tvalid_d;
            fb_q     <= fb_d;
            score_q  <= score_d;
            mist_q   <= mist_d;
            done_q   <= done_d;
            frame_q  <= frame_d;
            tcnt_q   <= tcnt_d;
            lfsr_q   <= lfsr_d;
        end
    end

    // Next-state and output decisions; everything except iStart waits for a frame tick.
    always_comb begin
        state_d    = state_q;
        screen_d   = screen_q;
        target_d   = target_q;
        tvalid_d   = tvalid_q;
        fb_d       = fb_q;
        score_d    = score_q;
        mist_d     = mist_q;
        done_d     = 1'b0;
        frame_d    = frame_q;
        tcnt_d     = tcnt_q;
        lfsr_d     = lfsr_q;
        target_end = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (iStart) begin
                    score_d  = 8'd0;
                    mist_d   = 8'd0;
                    tcnt_d   = 8'd0;
                    frame_d  = 8'd0;
                    lfsr_d   = LFSR_SEED;
                    fb_d     = FB_NONE;
                    target_d = TGT_NONE;
                    screen_d = SCR_PLAY;
                    state_d  = ST_ARM;
                end
            end
            ST_ARM: begin
                // Wait for hands off all pads so a held press cannot score the next target.
                if (tick && (pressed == 3'b000)) begin
                    target_d = lfsr_mod3;
                    lfsr_d   = lfsr_next;
                    frame_d  = 8'd0;
                    tvalid_d = 1'b1;
                    state_d  = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (tick) begin
                    target_end = 1'b1;
                    if (hit) begin
                        score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
                        fb_d    = FB_HIT;
                    end else if (wrong_pad) begin
                        mist_d  = mist_q + 8'd1;
                        fb_d    = FB_MISS;
                    end else if (frame_q == FPT_LAST) begin
                        mist_d  = mist_q + 8'd1;
                        fb_d    = FB_MISS;
                    end else begin
                        frame_d    = frame_q + 8'd1;
                        target_end = 1'b0;
                    end
                    if (target_end) begin
                        tcnt_d   = tcnt_q + 8'd1;
                        frame_d  = 8'd0;
                        tvalid_d = 1'b0;
                        state_d  = ST_FEEDBACK;
                    end
                end
            end
            ST_FEEDBACK: begin
                if (tick) begin
                    if (frame_q == FB_LAST) begin
                        frame_d  = 8'd0;
                        fb_d     = FB_NONE;
                        target_d = TGT_NONE;
                        if ((tcnt_q == TGT_TOTAL) || (mist_q == MIST_LIMIT)) begin
                            screen_d = SCR_RESULTS;
                            done_d   = 1'b1;
                            state_d  = ST_DONE;
                        end else begin
                            state_d  = ST_ARM;
                        end
                    end else begin
                        frame_d = frame_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign oScreen      = {30'd0, screen_q};
    assign oTarget      = target_q;
    assign oTargetValid = tvalid_q;
    assign oFeedback    = fb_q;
    assign oScore       = score_q;
    assign oMistake     = {24'd0, mist_q};
    assign oRoundDone   = done_q;

endmodule

// File: tb/tb_game_round_controller.sv
// Purpose: directed bench for game_round_controller with a per-cycle reference model and literal checkpoints.
// Latency: frames are 6 clocks; a frame's effect is visible 3 clocks after iVS falls.
// Backpressure: none; every wait is a fixed number of clock cycles.
module tb_game_round_controller;

    localparam int FPT  = 60;
    localparam int FBF  = 20;
    localparam int HITM = 40;
    localparam int NT   = 16;
    localparam int MM   = 3;

    localparam int PH_IDLE = 0;
    localparam int PH_ARM  = 1;
    localparam int PH_SHOW = 2;
    localparam int PH_FB   = 3;
    localparam int PH_DONE = 4;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        vs    = 1'b1;
    logic        start = 1'b0;
    logic [20:0] sensor = 21'd0;

    logic [31:0] oScreen;
    logic [1:0]  oTarget;
    logic        oTargetValid;
    logic [1:0]  oFeedback;
    logic [7:0]  oScore;
    logic [31:0] oMistake;
    logic        oRoundDone;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;

    // reference model state
    int m_ph = PH_IDLE, m_screen = 0, m_target = 3, m_valid = 0, m_fb = 0;
    int m_score = 0, m_mist = 0, m_done = 0, m_fc = 0, m_tc = 0, m_idx = 0;
    bit m_v1 = 1'b1, m_v2 = 1'b1, m_v3 = 1'b1;
    int seq [64];

    game_round_controller #(
        .FRAMES_PER_TARGET (FPT),
        .FEEDBACK_FRAMES   (FBF),
        .HIT_MAX           (HITM),
        .NUM_TARGETS       (NT),
        .MAX_MISTAKES      (MM),
        .LFSR_SEED         (8'hA5)
    ) dut (
        .iVGA_CLK     (clk),
        .iRST_n       (rst_n),
        .iVS          (vs),
        .iStart       (start),
        .iSensor      (sensor),
        .oScreen      (oScreen),
        .oTarget      (oTarget),
        .oTargetValid (oTargetValid),
        .oFeedback    (oFeedback),
        .oScore       (oScore),
        .oMistake     (oMistake),
        .oRoundDone   (oRoundDone)
    );

    always #5 clk = ~clk;

    function automatic bit pr(input logic [6:0] d);
        return (d != 7'd0) && (d < 7'(HITM));
    endfunction

    // Reference model: what the outputs must be after each clock edge, from the game rules.
    initial begin : model
        bit tk, p0, p1, p2, hit, any, fin;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_ph = PH_IDLE; m_screen = 0; m_target = 3; m_valid = 0; m_fb = 0;
                m_score = 0; m_mist = 0; m_done = 0; m_fc = 0; m_tc = 0; m_idx = 0;
                m_v1 = 1'b1; m_v2 = 1'b1; m_v3 = 1'b1;
            end else begin
                tk = m_v3 && !m_v2;
                m_v3 = m_v2; m_v2 = m_v1; m_v1 = vs;
                p0 = pr(sensor[6:0]);
                p1 = pr(sensor[13:7]);
                p2 = pr(sensor[20:14]);
                m_done = 0;
                case (m_ph)
                    PH_IDLE, PH_DONE: if (start) begin
                        m_score = 0; m_mist = 0; m_tc = 0; m_idx = 0;
                        m_ph = PH_ARM; m_screen = 1;
                    end
                    PH_ARM: if (tk && !(p0 || p1 || p2)) begin
                        m_target = seq[m_idx];
                        m_idx++;
                        m_fc = 0; m_valid = 1; m_ph = PH_SHOW;
                    end
                    PH_SHOW: if (tk) begin
                        hit = (m_target == 0 && p0) || (m_target == 1 && p1) || (m_target == 2 && p2);
                        any = p0 || p1 || p2;
                        m_fc++;
                        fin = 1'b1;
                        if (hit) begin
                            if (m_score < 255) m_score++;
                            m_fb = 1;
                        end else if (any || m_fc == FPT) begin
                            m_mist++;
                            m_fb = 2;
                        end else begin
                            fin = 1'b0;
                        end
                        if (fin) begin
                            m_tc++; m_fc = 0; m_valid = 0; m_ph = PH_FB;
                        end
                    end
                    PH_FB: if (tk) begin
                        m_fc++;
                        if (m_fc == FBF) begin
                            m_fb = 0; m_target = 3; m_fc = 0;
                            if (m_tc == NT || m_mist == MM) begin
                                m_ph = PH_DONE; m_screen = 2; m_done = 1;
                            end else begin
                                m_ph = PH_ARM;
                            end
                        end
                    end
                    default: m_ph = PH_IDLE;
                endcase
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin : compare
        forever begin
            @(negedge clk);
            total++;
            if (oScreen !== 32'(m_screen) || oTarget !== 2'(m_target) ||
                oTargetValid !== 1'(m_valid) || oFeedback !== 2'(m_fb) ||
                oScore !== 8'(m_score) || oMistake !== 32'(m_mist) ||
                oRoundDone !== 1'(m_done)) begin
                bad++;
                $display("FAIL outputs t=%0t got scr=%0d tgt=%0d vld=%0d fb=%0d sc=%0d mis=%0d done=%0d want scr=%0d tgt=%0d vld=%0d fb=%0d sc=%0d mis=%0d done=%0d",
                         $time, oScreen, oTarget, oTargetValid, oFeedback, oScore, oMistake, oRoundDone,
                         m_screen, m_target, m_valid, m_fb, m_score, m_mist, m_done);
            end
        end
    end

    // Count round-done pulses.
    initial begin : pulse_count
        forever begin
            @(negedge clk);
            if (oRoundDone === 1'b1) done_cnt++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic frame();
        @(negedge clk) vs = 1'b0;
        repeat (3) @(negedge clk);
        vs = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    // Short low pulse that never spans a rising clock edge.
    task automatic glitch();
        @(negedge clk);
        #1 vs = 1'b0;
        #2 vs = 1'b1;
    endtask

    task automatic start_pulse();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic set_pad(input int p, input logic [6:0] v);
        sensor[p*7 +: 7] = v;
    endtask

    initial begin : main
        logic [7:0] lf;
        lf = 8'hA5;
        for (int i = 0; i < 64; i++) begin
            seq[i] = int'(lf % 8'd3);
            lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
        end

        repeat (3) @(negedge clk);
        chk("rst_screen", oScreen, 0);
        chk("rst_target", 32'(oTarget), 3);
        chk("rst_valid", 32'(oTargetValid), 0);
        chk("rst_score", 32'(oScore), 0);
        chk("rst_mistake", oMistake, 0);
        rst_n = 1'b1;
        frame();
        chk("idle_hold", oScreen, 0);

        // arm and first hit: 0xA5 mod 3 = 0
        start_pulse();
        chk("start_screen", oScreen, 1);
        chk("start_valid", 32'(oTargetValid), 0);
        frame();
        chk("show1_valid", 32'(oTargetValid), 1);
        chk("show1_target", 32'(oTarget), 0);
        set_pad(0, 7'd20);
        frame();
        chk("hit_score", 32'(oScore), 1);
        chk("hit_fb", 32'(oFeedback), 1);
        chk("hit_valid", 32'(oTargetValid), 0);
        chk("fb_target_hold", 32'(oTarget), 0);
        set_pad(0, 7'd0);
        frames(FBF);
        chk("fb_end_target", 32'(oTarget), 3);
        chk("fb_end_fb", 32'(oFeedback), 0);

        // second target: 0x4A mod 3 = 2; wrong pad then arming hold
        frame();
        chk("show2_target", 32'(oTarget), 2);
        set_pad(1, 7'd10);
        frame();
        chk("wrong_mistake", oMistake, 1);
        chk("wrong_fb", 32'(oFeedback), 2);
        frames(FBF + 2);
        chk("arm_hold_valid", 32'(oTargetValid), 0);
        chk("arm_hold_screen", oScreen, 1);
        set_pad(1, 7'd0);
        frame();
        chk("show3_valid", 32'(oTargetValid), 1);
        chk("show3_target", 32'(oTarget), 2);

        // timeout; pad0 at exactly HIT_MAX is not a press; a glitch adds no frame
        set_pad(0, 7'd40);
        frames(FPT - 2);
        glitch();
        frame();
        chk("to59_mistake", oMistake, 1);
        chk("to59_valid", 32'(oTargetValid), 1);
        frame();
        chk("to60_mistake", oMistake, 2);
        chk("to60_fb", 32'(oFeedback), 2);
        set_pad(0, 7'd0);
        frames(FBF + 1);
        chk("show4_valid", 32'(oTargetValid), 1);
        frames(FPT);
        chk("to_third_mistake", oMistake, 3);
        done_cnt = 0;
        frames(FBF + 2);
        chk("early_done_screen", oScreen, 2);
        chk("early_done_mistake", oMistake, 3);
        chk("early_done_score", 32'(oScore), 1);
        chk("early_done_pulses", 32'(done_cnt), 1);

        // restart from DONE; same first target
        start_pulse();
        chk("restart_score", 32'(oScore), 0);
        chk("restart_mistake", oMistake, 0);
        chk("restart_screen", oScreen, 1);
        frame();
        chk("restart_target", 32'(oTarget), 0);

        // full session of hits, one with a simultaneous wrong pad
        done_cnt = 0;
        for (int k = 0; k < NT; k++) begin
            set_pad(m_target, 7'd20);
            if (k == 5) set_pad((m_target + 1) % 3, 7'd10);
            frame();
            sensor = 21'd0;
            frames(FBF);
            if (k < NT - 1) frame();
        end
        chk("full_screen", oScreen, 2);
        chk("full_score", 32'(oScore), 16);
        chk("full_mistake", oMistake, 0);
        chk("full_pulses", 32'(done_cnt), 1);

        // asynchronous reset in the middle of SHOW
        start_pulse();
        frame();
        set_pad(m_target, 7'd5);
        frame();
        sensor = 21'd0;
        frames(FBF + 1);
        chk("pre_rst_score", 32'(oScore), 1);
        chk("pre_rst_valid", 32'(oTargetValid), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_screen", oScreen, 0);
        chk("async_target", 32'(oTarget), 3);
        chk("async_score", 32'(oScore), 0);
        chk("async_mistake", oMistake, 0);
        chk("async_valid", 32'(oTargetValid), 0);
        @(negedge clk) rst_n = 1'b1;
        frames(2);
        chk("post_rst_idle", oScreen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_round_controller.md
Name: game_round_controller

Overview:
- Sequences one play session of the three-pad reaction game.
- Selects the screen for the VGA pixel path (splash / play / results) and picks a target pad.
- Times each target in video frames and judges the sensor distances as hit, wrong pad or timeout.
- Keeps score and mistake counts, and feeds the display block's screen, mistake and pad-highlight inputs.

Parameters:
- FRAMES_PER_TARGET, 60: frames a target stays live before a timeout mistake.
- FEEDBACK_FRAMES, 20: frames the hit/miss feedback is shown between targets.
- HIT_MAX, 40: a pad is "pressed" when its distance d satisfies 0 < d < HIT_MAX.
- NUM_TARGETS, 16: targets per session.
- MAX_MISTAKES, 3: mistakes that end a session early.
- LFSR_SEED, 8'hA5: target generator seed; nonzero.

Ports:
- iVGA_CLK, in, 1: pixel clock, the only clock.
- iRST_n, in, 1: asynchronous active-low reset.
- iVS, in, 1: vertical sync from the sync generator, active low, asynchronous to the FSM logic.
- iStart, in, 1: start request, one-cycle pulse, synchronous.
- iSensor, in, 21: three 7-bit distances; pad0 [6:0], pad1 [13:7], pad2 [20:14].
- oScreen, out, 32: 0 = splash, 1 = play, 2 = results.
- oTarget, out, 2: live target pad 0..2; 3 = none.
- oTargetValid, out, 1: target is live (SHOW state).
- oFeedback, out, 2: 01 = last judgement hit, 10 = miss, 00 = none.
- oScore, out, 8: hits this session, saturates at 255.
- oMistake, out, 32: mistakes this session, zero-extended count.
- oRoundDone, out, 1: one-cycle pulse on entry to DONE.

Behaviour:
- Reset (async, iRST_n low):
  - State IDLE; oScreen = 0; oTarget = 3; oTargetValid = 0; oFeedback = 0; oScore = 0; oMistake = 0; oRoundDone = 0.
  - LFSR = LFSR_SEED; all counters = 0.
  - Reset mid-session aborts immediately to this state.
- Frame tick:
  - iVS passes through a 2-flop synchronizer.
  - tick = one-cycle pulse on the synchronized 1->0 transition.
  - All judgement and frame counting happens only on tick cycles.
- Pressed(p) = (d_p != 0) && (d_p < HIT_MAX), using a 7-bit unsigned compare.
- IDLE (oScreen = 0):
  - On iStart: clear score, mistakes and target count; LFSR <= LFSR_SEED; go to ARM.
- ARM (oScreen = 1, oTargetValid = 0):
  - On the first tick with no pad pressed: oTarget <= LFSR mod 3; advance LFSR once; frame counter <= 0; go to SHOW.
  - LFSR is Fibonacci with taps 8,6,5,4; shift left, feedback into bit 0.
- SHOW (oTargetValid = 1, oFeedback = 0). Priority per tick:
  - (a) Pressed(oTarget): score +1 (saturating), oFeedback <= 01. Hit beats any other pad pressed in the same tick.
  - (b) else any other pad pressed: mistake +1, oFeedback <= 10.
  - (c) else if frame counter == FRAMES_PER_TARGET-1: timeout, mistake +1, oFeedback <= 10.
  - (d) else frame counter +1.
  - On (a), (b) or (c): target count +1, frame counter <= 0, oTargetValid <= 0, go to FEEDBACK. oTarget holds its value during FEEDBACK.
- FEEDBACK:
  - Counts FEEDBACK_FRAMES ticks; then oFeedback <= 0 and oTarget <= 3.
  - Go to DONE if target count == NUM_TARGETS or mistakes == MAX_MISTAKES; else go to ARM.
- DONE (oScreen = 2):
  - oRoundDone pulses one cycle on entry; score and mistakes hold.
  - iStart behaves as in IDLE, going straight to ARM.
- Other rules:
  - iStart outside IDLE/DONE is ignored.
  - Mistake count never exceeds MAX_MISTAKES within a session.
  - Outputs are registered; state changes take effect the cycle after the tick.

Test Plan:
- Reset check: assert iRST_n low mid-SHOW -> oScreen = 0, oTarget = 3, oScore = 0, oMistake = 0 asynchronously. After release, remains IDLE until iStart.
- Arming and hit: iStart, all sensors 0 -> first tick enters SHOW with oTarget = 0 (0xA5 mod 3). Pad0 = 20 on the next tick -> oScore = 1, oFeedback = 01, oTargetValid = 0 the following cycle.
- Wrong pad and arming hold: in SHOW with target 0, pad1 = 10 -> oMistake = 1, oFeedback = 10. Hold pad1 = 10 -> ARM does not leave until pad1 = 0 at a tick.
- Timeout: no presses, FRAMES_PER_TARGET = 60 -> mistake on exactly the 60th tick after SHOW entry, none on the 59th. Pad0 = 40 (equal to HIT_MAX) counts as not pressed.
- Early end: three consecutive timeouts -> DONE after the third FEEDBACK, oRoundDone pulses once, oScreen = 2, oMistake = 3. iStart -> ARM with oScore = 0, oMistake = 0, and the same first target 0.
- Full session and saturation: 16 hits -> DONE with oScore = 16. Simultaneous target and wrong-pad press -> counted as a hit. iVS glitch shorter than 2 clocks -> no extra frame counted.
